shift_right_seq_32: RTL and testbench



---
 rtl/shift_right_seq_32_pkg.sv | 17 +
 rtl/shift_right_seq_32.sv | 83 ++++++++
 tb/tb_shift_right_seq_32.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/shift_right_seq_32_pkg.sv
// Shared definitions for the sequential right shifter: state encoding,
// shift-mode constants and default datapath widths.
package shift_right_seq_32_pkg;

  localparam int SHR_WIDTH   = 32;
  localparam int SHR_SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } shr_state_t;

  localparam logic SHR_LOGIC = 1'b0;
  localparam logic SHR_ARITH = 1'b1;

endpackage : shift_right_seq_32_pkg

// File: rtl/shift_right_seq_32.sv
// Multi-cycle right shifter (SRL/SRA), one bit per clock, with a
// start/busy/done handshake. data_o is the working register itself.
module shift_right_seq_32
  import shift_right_seq_32_pkg::*;
#(
  parameter int WIDTH   = SHR_WIDTH,
  parameter int SHAMT_W = SHR_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o
);

  shr_state_t         state_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               mode_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               fill_bit;

  // Sign fill comes from the current MSB, which stays constant under SRA.
  assign fill_bit = (mode_reg == SHR_ARITH) ? data_reg[WIDTH-1] : 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= SHR_LOGIC;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            data_reg  <= data_i;
            count_reg <= shamt_i;
            mode_reg  <= arith_i;
            if (shamt_i == '0) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= BUSY;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        BUSY: begin
          data_reg  <= {fill_bit, data_reg[WIDTH-1:1]};
          count_reg <= count_reg - 1'b1;
          if (count_reg == SHAMT_W'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign data_o = data_reg;

endmodule : shift_right_seq_32

// File: tb/tb_shift_right_seq_32.sv
// Scoreboard bench for shift_right_seq_32: stimulus pushes expected results,
// a negedge monitor pops and compares on every done_o pulse.
module tb_shift_right_seq_32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        arith_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  typedef struct {
    logic [31:0] data;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  shift_right_seq_32 dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: counts busy cycles since the previous done, compares on done.
  initial begin : monitor
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        busy_cnt = 0;
      end else begin
        if (busy_o) busy_cnt++;
        if (done_o) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got data %h, expected no done pulse", data_o);
          end else begin
            e = exp_q.pop_front();
            check("result", data_o, e.data);
            check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Drive one start pulse (inputs set on negedge, sampled at next posedge).
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a,
                       input logic [31:0] res, input bit push);
    exp_t e;
    data_i  = d;
    shamt_i = s;
    arith_i = a;
    start_i = 1'b1;
    if (push) begin
      e.data = res;
      e.busy = int'(s);
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (done_o) return;
      @(negedge clk_i);
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s_timeout: got no done_o within 40 cycles, expected done_o=1", name);
  endtask

  task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input logic [31:0] res);
    @(negedge clk_i);
    issue(d, s, a, res, 1'b1);
    wait_done(name);
    @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_data", data_o, 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_done", 32'(done_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_op("srl4",    32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    run_op("sra31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("srl31",   32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("zero",    32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678);
    run_op("sra_pos", 32'h7000_0000, 5'd3,  1'b1, 32'h0E00_0000);
    run_op("sra_neg", 32'hC000_00F0, 5'd4,  1'b1, 32'hFC00_000F);

    // Start pulse mid-BUSY must be ignored
    @(negedge clk_i);
    issue(32'hF000_0000, 5'd8, 1'b0, 32'h00F0_0000, 1'b1);
    repeat (2) @(negedge clk_i);
    issue(32'h0000_0001, 5'd1, 1'b1, 32'h0, 1'b0);
    wait_done("ignored");
    repeat (6) @(negedge clk_i);

    // Asynchronous reset in the middle of an operation
    issue(32'h8000_0000, 5'd20, 1'b1, 32'h0, 1'b0);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_data", data_o, 32'h0);
    check("midrst_busy", 32'(busy_o), 32'h0);
    check("midrst_done", 32'(done_o), 32'h0);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    run_op("post_rst_sra", 32'hFFFF_FF00, 5'd8, 1'b1, 32'hFFFF_FFFF);

    // Back-to-back: new start accepted in the DONE cycle
    @(negedge clk_i);
    issue(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF, 1'b1);
    wait_done("b2b_first");
    issue(32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 1'b1);
    check("b2b_no_bubble", 32'(busy_o), 32'h1);
    wait_done("b2b_second");
    repeat (6) @(negedge clk_i);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_shift_right_seq_32
